// File: rtl/mem_write_arbiter.sv
// Round-robin arbiter sharing one single-beat go/ready write master
// between NUM_REQ requesters; one go pulse and one ack per write.
module mem_write_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      m_go,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_data,
    input  logic                      m_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    state_t              state, state_n;
    logic [IW-1:0]       last, last_n;
    logic [IW-1:0]       win, win_n;
    logic [IW-1:0]       pick, cand;
    logic                found;
    logic [CW-1:0]       cnt, cnt_n;
    logic [NUM_REQ-1:0]  ack_n, grant_n;
    logic                go_n, busy_n, err_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [DATA_W-1:0]   data_n;

    // Search starts just after the last completed winner
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            last        <= IW'(NUM_REQ - 1);
            win         <= '0;
            cnt         <= '0;
            ack         <= '0;
            m_go        <= 1'b0;
            m_addr      <= '0;
            m_data      <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            last        <= last_n;
            win         <= win_n;
            cnt         <= cnt_n;
            ack         <= ack_n;
            m_go        <= go_n;
            m_addr      <= addr_n;
            m_data      <= data_n;
            grant       <= grant_n;
            busy        <= busy_n;
            timeout_err <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (m_ready && found) state_n = ISSUE;
            ISSUE:   state_n = BUSY;
            BUSY:    if (m_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ack_n   = '0;
        go_n    = 1'b0;
        addr_n  = m_addr;
        data_n  = m_data;
        grant_n = grant;
        busy_n  = busy;
        err_n   = timeout_err;
        last_n  = last;
        win_n   = win;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                grant_n = '0;
                busy_n  = 1'b0;
                if (m_ready && found) begin
                    go_n    = 1'b1;
                    win_n   = pick;
                    addr_n  = req_addr[int'(pick)*ADDR_W +: ADDR_W];
                    data_n  = req_data[int'(pick)*DATA_W +: DATA_W];
                    grant_n = NUM_REQ'(1) << pick;
                    busy_n  = 1'b1;
                end
            end
            ISSUE: cnt_n = '0;
            BUSY: begin
                if (m_ready) begin
                    ack_n[win] = 1'b1;
                    grant_n    = '0;
                    busy_n     = 1'b0;
                    last_n     = win;
                end else if (cnt != CW'(TIMEOUT_CYCLES)) begin
                    cnt_n = cnt + 1'b1;
                end
                if (cnt_n == CW'(TIMEOUT_CYCLES)) err_n = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed bench for mem_write_arbiter with a behavioural
// go/ready write master whose wait states the bench controls.
module tb_mem_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic            m_go;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_data;
    logic            m_ready;
    logic [N-1:0]    grant;
    logic            busy;
    logic            timeout_err;

    logic ready_q;
    logic hold;
    int   wcnt;
    int   wait_n;
    int   total = 0;
    int   bad   = 0;
    int   gi;

    mem_write_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .resetn(resetn), .req(req),
        .req_addr(req_addr), .req_data(req_data), .ack(ack),
        .m_go(m_go), .m_addr(m_addr), .m_data(m_data),
        .m_ready(m_ready), .grant(grant), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Master: busy from the cycle after go, idle again after wait_n extra cycles
    assign m_ready = ready_q & ~hold;
    always @(posedge clk) begin
        if (!resetn) begin
            ready_q <= 1'b1;
            wcnt    <= 0;
        end else if (m_go) begin
            ready_q <= 1'b0;
            wcnt    <= wait_n;
        end else if (!ready_q) begin
            if (wcnt == 0) ready_q <= 1'b1;
            else wcnt <= wcnt - 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_go"}, m_go, 0);
        chk({tag, "_addr"}, m_addr, 0);
        chk({tag, "_data"}, m_data, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, timeout_err, 0);
    endtask

    initial begin
        resetn = 1'b0;
        req    = '0;
        hold   = 1'b0;
        wait_n = 0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = 32'h1000 + 32'(i * 16);
            req_data[i*DW +: DW] = 32'hA000_0000 + 32'(i);
        end
        tick;
        tick;
        chk_reset_vals("rst");
        resetn = 1'b1;
        tick;

        // Single request, zero-wait master
        req_addr[0 +: AW] = 32'h100;
        req_data[0 +: DW] = 32'hDEAD_BEEF;
        req = 4'b0001;
        tick;
        chk("s_go1", m_go, 1);
        chk("s_addr", m_addr, 32'h100);
        chk("s_data", m_data, 32'hDEAD_BEEF);
        chk("s_grant", grant, 4'b0001);
        chk("s_busy1", busy, 1);
        tick;
        chk("s_go2", m_go, 0);
        chk("s_busy2", busy, 1);
        tick;
        chk("s_busy3", busy, 1);
        chk("s_ack3", ack, 0);
        tick;
        chk("s_ack4", ack, 4'b0001);
        chk("s_busy4", busy, 0);
        chk("s_grant4", grant, 0);
        req = '0;
        tick;
        chk("s_ack5", ack, 0);
        chk("s_go5", m_go, 0);

        // Round robin from a fresh reset
        req_addr[0 +: AW] = 32'h1000;
        req_data[0 +: DW] = 32'hA000_0000;
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        req = 4'b1111;
        for (int c = 1; c <= 24; c++) begin
            tick;
            gi = ((c - 1) / 4) % 4;
            chk("rr_go", m_go, 64'(c % 4 == 1));
            chk("rr_grant", grant, (c % 4 == 0) ? 64'd0 : 64'd1 << gi);
            if (c % 4 == 1) chk("rr_addr", m_addr, 32'h1000 + 32'(gi * 16));
            chk("rr_ack", ack,
                (c % 4 == 0) ? 64'd1 << (((c - 4) / 4) % 4) : 64'd0);
        end
        req = '0;
        tick;
        chk("rr_idle", m_go, 0);

        // Five wait states on requester 2
        wait_n = 5;
        req = 4'b0100;
        for (int c = 1; c <= 9; c++) begin
            tick;
            chk("ws_go", m_go, 64'(c == 1));
            chk("ws_addr", m_addr, 32'h1020);
            chk("ws_data", m_data, 32'hA000_0002);
            chk("ws_ack", ack, (c == 9) ? 64'd4 : 64'd0);
        end
        req = '0;
        wait_n = 0;
        tick;
        chk("ws_err", timeout_err, 0);

        // Master not ready in IDLE
        hold = 1'b1;
        req = 4'b0010;
        for (int c = 1; c <= 3; c++) begin
            tick;
            chk("nr_go", m_go, 0);
            chk("nr_busy", busy, 0);
        end
        hold = 1'b0;
        tick;
        chk("nr_go_after", m_go, 1);
        chk("nr_grant", grant, 4'b0010);
        tick;
        tick;
        tick;
        chk("nr_ack", ack, 4'b0010);
        req = '0;
        tick;

        // Timeout with the master stuck busy
        req = 4'b0001;
        tick;
        chk("to_go", m_go, 1);
        hold = 1'b1;
        for (int c = 2; c <= 9; c++) tick;
        chk("to_err9", timeout_err, 0);
        tick;
        chk("to_err10", timeout_err, 1);
        chk("to_busy10", busy, 1);
        for (int c = 11; c <= 14; c++) tick;
        chk("to_err14", timeout_err, 1);
        chk("to_ack14", ack, 0);
        hold = 1'b0;
        tick;
        chk("to_ack15", ack, 4'b0001);
        chk("to_err15", timeout_err, 1);
        req = '0;
        tick;
        chk("to_err16", timeout_err, 1);
        chk("to_busy16", busy, 0);

        // Reset during requester 1's write
        req = 4'b0010;
        tick;
        chk("mr_grant", grant, 4'b0010);
        hold = 1'b1;
        tick;
        tick;
        chk("mr_busy", busy, 1);
        resetn = 1'b0;
        tick;
        chk_reset_vals("mr");
        resetn = 1'b1;
        hold = 1'b0;
        req = 4'b0011;
        tick;
        chk("mr_go", m_go, 1);
        chk("mr_grant0", grant, 4'b0001);
        tick;
        chk("mr_ack6", ack, 0);
        tick;
        chk("mr_ack7", ack, 0);
        tick;
        chk("mr_ack8", ack, 4'b0001);
        req = 4'b0010;
        tick;
        chk("mr_grant1", grant, 4'b0010);
        tick;
        tick;
        tick;
        chk("mr_ack12", ack, 4'b0010);
        req = '0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
